// File: rtl/mfp_ahb_sevenseg_scanner.sv
// Eight-digit seven-segment scan controller: guarded per-digit multiplexing
// with a double-buffered frame that only switches at the end of a full scan.
module mfp_ahb_sevenseg_scanner #(
    parameter int DIV_CYCLES   = 50000,
    parameter int GUARD_CYCLES = 500,
    parameter int CNT_W        = 17
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        upd_valid,
    input  logic [47:0] upd_codes,
    input  logic [7:0]  upd_en,
    output logic        upd_ready,
    output logic [5:0]  disp_code,
    output logic [7:0]  disp_an_n,
    output logic        frame_done
);

    typedef enum logic {ST_GUARD = 1'b0, ST_ON = 1'b1} state_t;

    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       digit_q;
    logic [7:0][5:0]  act_codes_q;
    logic [7:0]       act_en_q;
    logic [7:0][5:0]  pend_codes_q;
    logic [7:0]       pend_en_q;
    logic             pend_full_q;
    logic             ready_q;
    logic [7:0]       an_q;
    logic [5:0]       code_q;
    logic             done_q;
    logic             accept_s;
    logic             boundary_s;

    assign accept_s   = upd_valid && ready_q;
    assign boundary_s = (state_q == ST_ON) && (cnt_q == DIV_LAST) && (digit_q == 3'd7);

    assign upd_ready  = ready_q;
    assign disp_code  = code_q;
    assign disp_an_n  = an_q;
    assign frame_done = done_q;

    // Scan FSM: phase counter, digit index and the registered anode/code drive.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_GUARD;
            cnt_q   <= '0;
            digit_q <= 3'd0;
            an_q    <= 8'hFF;
            code_q  <= 6'h3F;
            done_q  <= 1'b0;
        end else begin
            done_q <= boundary_s;
            case (state_q)
                ST_GUARD: begin
                    if (cnt_q == GUARD_LAST) begin
                        state_q <= ST_ON;
                        cnt_q   <= '0;
                        an_q    <= act_en_q[digit_q] ? ~(8'b1 << digit_q) : 8'hFF;
                        code_q  <= act_codes_q[digit_q];
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                ST_ON: begin
                    // Anode and code blank on the same edge, so no digit ever sees a stale code.
                    if (cnt_q == DIV_LAST) begin
                        state_q <= ST_GUARD;
                        cnt_q   <= '0;
                        digit_q <= digit_q + 3'd1;
                        an_q    <= 8'hFF;
                        code_q  <= 6'h3F;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_GUARD;
                    cnt_q   <= '0;
                    digit_q <= 3'd0;
                    an_q    <= 8'hFF;
                    code_q  <= 6'h3F;
                end
            endcase
        end
    end

    // Frame buffers: capture into the pending slot, promote to active only at the boundary.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            act_codes_q  <= {8{6'h3F}};
            act_en_q     <= 8'h00;
            pend_codes_q <= '0;
            pend_en_q    <= 8'h00;
            pend_full_q  <= 1'b0;
            ready_q      <= 1'b1;
        end else if (accept_s) begin
            pend_codes_q <= upd_codes;
            pend_en_q    <= upd_en;
            pend_full_q  <= 1'b1;
            ready_q      <= 1'b0;
        end else if (boundary_s && pend_full_q) begin
            act_codes_q  <= pend_codes_q;
            act_en_q     <= pend_en_q;
            pend_full_q  <= 1'b0;
            ready_q      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mfp_ahb_sevenseg_scanner.sv
// Directed bench for the seven-segment scanner: table of frames with hand-computed
// anode/code expectations, checked cycle by cycle against a frame-position model.
module tb_mfp_ahb_sevenseg_scanner;

    localparam int DIV   = 4;
    localparam int GUARD = 2;
    localparam int SLOT  = DIV + GUARD;
    localparam int FRAME = 8 * SLOT;

    logic        HCLK;
    logic        HRESETn;
    logic        upd_valid;
    logic [47:0] upd_codes;
    logic [7:0]  upd_en;
    logic        upd_ready;
    logic [5:0]  disp_code;
    logic [7:0]  disp_an_n;
    logic        frame_done;

    mfp_ahb_sevenseg_scanner #(
        .DIV_CYCLES  (DIV),
        .GUARD_CYCLES(GUARD),
        .CNT_W       (17)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .upd_valid (upd_valid),
        .upd_codes (upd_codes),
        .upd_en    (upd_en),
        .upd_ready (upd_ready),
        .disp_code (disp_code),
        .disp_an_n (disp_an_n),
        .frame_done(frame_done)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [47:0]     codes;
        logic [7:0]      en;
        logic [7:0][7:0] exp_an;
        logic [7:0][5:0] exp_code;
    } vec_t;

    vec_t vecs [4];
    vec_t blank;
    vec_t mcur;
    vec_t mpend;
    vec_t offered;
    bit   mpend_full;
    int   kcnt;
    int   checks;
    int   errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, kcnt, act, exp);
        end
    endtask

    task automatic offer(input vec_t v);
        offered   = v;
        upd_valid = 1'b1;
        upd_codes = v.codes;
        upd_en    = v.en;
    endtask

    // One clock: advance the model on the edge, then compare all outputs on the falling edge.
    task automatic tick();
        bit acc;
        int p;
        int slot;
        int ph;
        acc = upd_valid && !mpend_full;
        @(posedge HCLK);
        kcnt++;
        p = kcnt % FRAME;
        if (acc) begin
            mpend      = offered;
            mpend_full = 1'b1;
        end else if (p == 0 && mpend_full) begin
            mcur       = mpend;
            mpend_full = 1'b0;
        end
        @(negedge HCLK);
        slot = p / SLOT;
        ph   = p % SLOT;
        if (ph < GUARD) begin
            chk("anode_guard", disp_an_n, 8'hFF);
            chk("code_guard", disp_code, 6'h3F);
        end else begin
            chk("anode_on", disp_an_n, mcur.exp_an[slot]);
            chk("code_on", disp_code, mcur.exp_code[slot]);
        end
        chk("frame_done", frame_done, (p == 0) ? 1'b1 : 1'b0);
        chk("upd_ready", upd_ready, mpend_full ? 1'b0 : 1'b1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        kcnt   = 0;

        blank.codes    = {8{6'h3F}};
        blank.en       = 8'h00;
        blank.exp_an   = {8{8'hFF}};
        blank.exp_code = {8{6'h3F}};

        vecs[0].codes    = {6'h07, 6'h06, 6'h05, 6'h04, 6'h03, 6'h02, 6'h01, 6'h00};
        vecs[0].en       = 8'hFF;
        vecs[0].exp_an   = {8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
        vecs[0].exp_code = {6'h07, 6'h06, 6'h05, 6'h04, 6'h03, 6'h02, 6'h01, 6'h00};

        vecs[1].codes    = {6'h07, 6'h06, 6'h05, 6'h04, 6'h23, 6'h02, 6'h01, 6'h00};
        vecs[1].en       = 8'hFF;
        vecs[1].exp_an   = {8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
        vecs[1].exp_code = {6'h07, 6'h06, 6'h05, 6'h04, 6'h23, 6'h02, 6'h01, 6'h00};

        vecs[2].codes    = {6'h17, 6'h16, 6'h15, 6'h14, 6'h13, 6'h12, 6'h11, 6'h10};
        vecs[2].en       = 8'hAA;
        vecs[2].exp_an   = {8'h7F, 8'hFF, 8'hDF, 8'hFF, 8'hF7, 8'hFF, 8'hFD, 8'hFF};
        vecs[2].exp_code = {6'h17, 6'h16, 6'h15, 6'h14, 6'h13, 6'h12, 6'h11, 6'h10};

        vecs[3].codes    = {6'h3E, 6'h2D, 6'h1C, 6'h0B, 6'h31, 6'h22, 6'h13, 6'h04};
        vecs[3].en       = 8'h55;
        vecs[3].exp_an   = {8'hFF, 8'hBF, 8'hFF, 8'hEF, 8'hFF, 8'hFB, 8'hFF, 8'hFE};
        vecs[3].exp_code = {6'h3E, 6'h2D, 6'h1C, 6'h0B, 6'h31, 6'h22, 6'h13, 6'h04};

        mcur       = blank;
        mpend      = blank;
        offered    = blank;
        mpend_full = 1'b0;

        HRESETn   = 1'b0;
        upd_valid = 1'b0;
        upd_codes = 48'h0;
        upd_en    = 8'h00;
        repeat (5) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_anode", disp_an_n, 8'hFF);
        chk("rst_code", disp_code, 6'h3F);
        chk("rst_ready", upd_ready, 1'b1);
        chk("rst_done", frame_done, 1'b0);
        HRESETn = 1'b1;
        kcnt    = 0;

        // Blank first frame; first frame_done lands on edge 48.
        repeat (FRAME) tick();

        // Tear-free updates: each frame is offered mid-scan while the previous one displays.
        for (int i = 0; i < 4; i++) begin
            repeat (20) tick();
            offer(vecs[i]);
            tick();
            upd_valid = 1'b0;
            repeat (FRAME - 21) tick();
        end

        // Offer on the boundary edge with the slot empty: captured, committed one frame later.
        repeat (FRAME - 1) tick();
        offer(vecs[0]);
        tick();
        upd_valid = 1'b0;
        chk("bnd_capture_ready", upd_ready, 1'b0);
        repeat (FRAME) tick();

        // Back-pressure: C held while B is pending; C is taken on the edge after ready rises.
        repeat (9) tick();
        offer(vecs[1]);
        tick();
        offer(vecs[2]);
        repeat (FRAME - 10) tick();
        chk("bp_ready_after_commit", upd_ready, 1'b1);
        tick();
        upd_valid = 1'b0;
        chk("bp_c_captured", upd_ready, 1'b0);
        repeat (FRAME - 1) tick();
        repeat (FRAME) tick();

        // Asynchronous reset during digit 5 ON with a frame pending.
        repeat (20) tick();
        offer(vecs[3]);
        tick();
        upd_valid = 1'b0;
        repeat (12) tick();
        chk("pre_reset_digit5", disp_an_n, 8'hDF);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("async_anode", disp_an_n, 8'hFF);
        chk("async_code", disp_code, 6'h3F);
        chk("async_ready", upd_ready, 1'b1);
        chk("async_done", frame_done, 1'b0);
        mcur       = blank;
        mpend_full = 1'b0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        kcnt    = 0;
        repeat (FRAME) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
